// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 opcodes, addressing modes and parameter-count lookup.
// Used by the driver and by the loopback receiver.
package ssd1306_pkg;

  localparam logic [7:0] CMD_SET_MODE   = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR   = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR  = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF   = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON    = 8'hAF;
  localparam logic [7:0] CMD_PAGE_START = 8'hB0;

  typedef enum logic [1:0] {
    HORIZ = 2'd0,
    VERT  = 2'd1,
    PAGE  = 2'd2
  } addr_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PARAM = 2'd1,
    SKIP  = 2'd2
  } dec_state_t;

  // Number of parameter bytes following an opcode (0 for single-byte commands).
  function automatic logic [2:0] param_count(input logic [7:0] opcode);
    case (opcode)
      CMD_SET_MODE, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB:             return 3'd1;
      CMD_COL_ADDR, CMD_PAGE_ADDR, 8'hA3:     return 3'd2;
      8'h29, 8'h2A:                           return 3'd5;
      8'h26, 8'h27:                           return 3'd6;
      default:                                return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_if.sv
// SPI link from the driver plus frame-buffer and status outputs of the receiver.
// master = SPI source / observer, slave = receiver.
interface ssd1306_spi_receiver_if #(
  parameter int COLUMNS = 128,
  parameter int PAGES   = 8
);
  localparam int AW = $clog2(COLUMNS * PAGES);

  logic          oled_csn;
  logic          oled_dc;
  logic          oled_clk;
  logic          oled_mosi;
  logic          oled_rstn;

  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          display_on;
  logic          byte_stb;
  logic [7:0]    byte_out;
  logic          byte_is_data;
  logic          frame_err;

  modport master (
    output oled_csn, oled_dc, oled_clk, oled_mosi, oled_rstn,
    input  fb_we, fb_addr, fb_data, display_on, byte_stb, byte_out, byte_is_data, frame_err
  );

  modport slave (
    input  oled_csn, oled_dc, oled_clk, oled_mosi, oled_rstn,
    output fb_we, fb_addr, fb_data, display_on, byte_stb, byte_out, byte_is_data, frame_err
  );

endinterface

// File: rtl/ssd1306_spi_deser.sv
// SPI deserializer: input synchronizers, sclk edge detect, MSB-first shift, framing check.
// byte_stb_o pulses the cycle after the 8th detected rising edge; no backpressure.
module ssd1306_spi_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       csn_i,
  input  logic       dc_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       rstn_i,
  output logic       soft_rst_o,
  output logic       byte_stb_o,
  output logic [7:0] byte_o,
  output logic       byte_is_data_o,
  output logic       frame_err_o
);

  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_s;
  logic       rstn_s, csn_s, dc_s, sclk_s, mosi_s;

  logic       sclk_prev_q, csn_prev_q;
  logic [6:0] shift_q;
  logic [2:0] cnt_q;
  logic       byte_stb_q, is_data_q, frame_err_q;
  logic [7:0] byte_q;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign {rstn_s, csn_s, dc_s, sclk_s, mosi_s} = sync_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {rstn_i, csn_i, dc_i, sclk_i, mosi_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      byte_stb_q  <= 1'b0;
      byte_q      <= '0;
      is_data_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      byte_stb_q  <= 1'b0;
      if (!rstn_s) begin
        shift_q     <= '0;
        cnt_q       <= '0;
        byte_q      <= '0;
        is_data_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end else if (csn_s && !csn_prev_q) begin
        // Deselect in the middle of a byte drops the partial byte.
        if (cnt_q != 3'd0) frame_err_q <= 1'b1;
        cnt_q <= '0;
      end else if (!csn_s && csn_prev_q) begin
        cnt_q <= '0;
      end else if (!csn_s && sclk_s && !sclk_prev_q) begin
        shift_q <= {shift_q[5:0], mosi_s};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_stb_q <= 1'b1;
          byte_q     <= {shift_q, mosi_s};
          is_data_q  <= dc_s;
        end
      end
    end
  end

  assign soft_rst_o     = ~rstn_s;
  assign byte_stb_o     = byte_stb_q;
  assign byte_o         = byte_q;
  assign byte_is_data_o = is_data_q;
  assign frame_err_o    = frame_err_q;

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 SPI responder: command decoder, address pointer and GDDRAM write strobes.
// fb_we follows byte_stb by one cycle with the pre-increment address; no backpressure.
module ssd1306_spi_receiver
  import ssd1306_pkg::*;
#(
  parameter int COLUMNS     = 128,
  parameter int PAGES       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ssd1306_spi_receiver_if.slave  bus
);

  localparam int CW = $clog2(COLUMNS);
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int AW = $clog2(COLUMNS * PAGES);
  localparam logic [CW-1:0] COL_MAX = CW'(COLUMNS - 1);
  localparam logic [PW-1:0] PG_MAX  = PW'(PAGES - 1);

  function automatic logic [CW-1:0] clip_col(input logic [7:0] v);
    return (32'(v) > 32'(COLUMNS - 1)) ? COL_MAX : CW'(v);
  endfunction

  function automatic logic [PW-1:0] clip_pg(input logic [7:0] v);
    return (32'(v) > 32'(PAGES - 1)) ? PG_MAX : PW'(v);
  endfunction

  logic       soft_rst, stb_w, is_data_w, frame_err_w;
  logic [7:0] byte_w;

  ssd1306_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .csn_i          (bus.oled_csn),
    .dc_i           (bus.oled_dc),
    .sclk_i         (bus.oled_clk),
    .mosi_i         (bus.oled_mosi),
    .rstn_i         (bus.oled_rstn),
    .soft_rst_o     (soft_rst),
    .byte_stb_o     (stb_w),
    .byte_o         (byte_w),
    .byte_is_data_o (is_data_w),
    .frame_err_o    (frame_err_w)
  );

  dec_state_t    state_q;
  addr_mode_t    mode_q;
  logic [7:0]    op_q;
  logic          pidx_q;
  logic [2:0]    skip_q;
  logic [CW-1:0] col_q, col_start_q, col_end_q;
  logic [PW-1:0] page_q, pg_start_q, pg_end_q;
  logic          disp_q, fb_we_q;
  logic [AW-1:0] fb_addr_q;
  logic [7:0]    fb_data_q;

  logic [CW-1:0] col_lim, col_inc, col_d;
  logic [PW-1:0] pg_lim, pg_inc, page_d;
  logic          col_wrap, pg_wrap;
  logic [7:0]    col8;

  assign col8 = 8'(col_q);

  // A reversed range wraps at the physical edge instead of the end value.
  always_comb begin
    col_lim  = (col_start_q <= col_end_q) ? col_end_q : COL_MAX;
    pg_lim   = (pg_start_q <= pg_end_q) ? pg_end_q : PG_MAX;
    col_wrap = (col_q == col_lim) || (col_q == COL_MAX);
    pg_wrap  = (page_q == pg_lim) || (page_q == PG_MAX);
    col_inc  = col_wrap ? col_start_q : col_q + 1'b1;
    pg_inc   = pg_wrap ? pg_start_q : page_q + 1'b1;
    col_d    = col_inc;
    page_d   = page_q;
    case (mode_q)
      HORIZ: if (col_wrap) page_d = pg_inc;
      VERT: begin
        page_d = pg_inc;
        col_d  = pg_wrap ? col_inc : col_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_q      <= PAGE;
      op_q        <= '0;
      pidx_q      <= 1'b0;
      skip_q      <= '0;
      col_q       <= '0;
      col_start_q <= '0;
      col_end_q   <= COL_MAX;
      page_q      <= '0;
      pg_start_q  <= '0;
      pg_end_q    <= PG_MAX;
      disp_q      <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
    end else if (soft_rst) begin
      state_q     <= IDLE;
      mode_q      <= PAGE;
      op_q        <= '0;
      pidx_q      <= 1'b0;
      skip_q      <= '0;
      col_q       <= '0;
      col_start_q <= '0;
      col_end_q   <= COL_MAX;
      page_q      <= '0;
      pg_start_q  <= '0;
      pg_end_q    <= PG_MAX;
      disp_q      <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
    end else begin
      fb_we_q <= 1'b0;
      if (stb_w && is_data_w) begin
        // Data is written regardless of decoder state; the decoder does not advance.
        fb_we_q   <= 1'b1;
        fb_addr_q <= AW'(page_q) * AW'(COLUMNS) + AW'(col_q);
        fb_data_q <= byte_w;
        col_q     <= col_d;
        page_q    <= page_d;
      end else if (stb_w) begin
        case (state_q)
          IDLE: begin
            if (param_count(byte_w) != 3'd0) begin
              if (byte_w == CMD_SET_MODE || byte_w == CMD_COL_ADDR || byte_w == CMD_PAGE_ADDR) begin
                state_q <= PARAM;
                op_q    <= byte_w;
                pidx_q  <= 1'b0;
              end else begin
                state_q <= SKIP;
                skip_q  <= param_count(byte_w);
              end
            end else if (byte_w[7:4] == 4'h0) begin
              if (mode_q == PAGE) col_q <= clip_col({col8[7:4], byte_w[3:0]});
            end else if (byte_w[7:4] == 4'h1) begin
              if (mode_q == PAGE) col_q <= clip_col({byte_w[3:0], col8[3:0]});
            end else if (byte_w[7:3] == CMD_PAGE_START[7:3]) begin
              page_q <= PW'(32'(byte_w[2:0]) % PAGES);
            end else if (byte_w == CMD_DISP_OFF) begin
              disp_q <= 1'b0;
            end else if (byte_w == CMD_DISP_ON) begin
              disp_q <= 1'b1;
            end
          end
          PARAM: begin
            case (op_q)
              CMD_SET_MODE: begin
                mode_q  <= (byte_w[1:0] == 2'd3) ? PAGE : addr_mode_t'(byte_w[1:0]);
                state_q <= IDLE;
              end
              CMD_COL_ADDR: begin
                if (!pidx_q) begin
                  col_start_q <= clip_col(byte_w);
                  col_q       <= clip_col(byte_w);
                  pidx_q      <= 1'b1;
                end else begin
                  col_end_q <= clip_col(byte_w);
                  state_q   <= IDLE;
                end
              end
              default: begin
                if (!pidx_q) begin
                  pg_start_q <= clip_pg(byte_w);
                  page_q     <= clip_pg(byte_w);
                  pidx_q     <= 1'b1;
                end else begin
                  pg_end_q <= clip_pg(byte_w);
                  state_q  <= IDLE;
                end
              end
            endcase
          end
          default: begin
            skip_q <= skip_q - 3'd1;
            if (skip_q <= 3'd1) state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.fb_we        = fb_we_q;
  assign bus.fb_addr      = fb_addr_q;
  assign bus.fb_data      = fb_data_q;
  assign bus.display_on   = disp_q;
  assign bus.byte_stb     = stb_w;
  assign bus.byte_out     = byte_w;
  assign bus.byte_is_data = is_data_w;
  assign bus.frame_err    = frame_err_w;

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Bench for ssd1306_spi_receiver: directed scenarios plus random command/data traffic,
// scored against a behavioural display model through an expectation queue.
module tb_ssd1306_spi_receiver;

  localparam int COLUMNS = 128;
  localparam int PAGES   = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  ssd1306_spi_receiver_if #(.COLUMNS(COLUMNS), .PAGES(PAGES)) bus ();

  ssd1306_spi_receiver #(.COLUMNS(COLUMNS), .PAGES(PAGES), .SYNC_STAGES(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    bit         dc;
    logic [7:0] b;
    int         addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Behavioural model of the panel state
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_op, m_left;
  bit m_disp, m_ferr;

  task automatic model_reset();
    m_mode = 2; m_col = 0; m_page = 0;
    m_cs = 0; m_ce = COLUMNS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_op = 0; m_left = 0; m_disp = 0; m_ferr = 0;
  endtask

  function automatic int nparams(input logic [7:0] b);
    case (b)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: return 1;
      8'h21, 8'h22, 8'hA3: return 2;
      8'h29, 8'h2A: return 5;
      8'h26, 8'h27: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int clip(input int v, input int n);
    return (v > n - 1) ? n - 1 : v;
  endfunction

  // Advance v within [s..e] (or [s..n-1] if reversed); carry set on wrap.
  function automatic int nxt(input int v, input int s, input int e, input int n, output bit carry);
    int last;
    last  = (s <= e) ? e : n - 1;
    carry = (v == last) || (v == n - 1);
    return carry ? s : v + 1;
  endfunction

  task automatic model_byte(input bit dc, input logic [7:0] b);
    exp_t e;
    bit   c;
    e.dc = dc; e.b = b; e.addr = -1;
    if (dc) begin
      e.addr = m_page * COLUMNS + m_col;
      if (m_mode == 0) begin
        m_col = nxt(m_col, m_cs, m_ce, COLUMNS, c);
        if (c) m_page = nxt(m_page, m_ps, m_pe, PAGES, c);
      end else if (m_mode == 1) begin
        m_page = nxt(m_page, m_ps, m_pe, PAGES, c);
        if (c) m_col = nxt(m_col, m_cs, m_ce, COLUMNS, c);
      end else begin
        m_col = nxt(m_col, m_cs, m_ce, COLUMNS, c);
      end
    end else if (m_left > 0) begin
      if (m_op == 'h20) m_mode = (b[1:0] == 2'd3) ? 2 : int'(b[1:0]);
      else if (m_op == 'h21 && m_left == 2) begin m_cs = clip(int'(b), COLUMNS); m_col = m_cs; end
      else if (m_op == 'h21) m_ce = clip(int'(b), COLUMNS);
      else if (m_op == 'h22 && m_left == 2) begin m_ps = clip(int'(b), PAGES); m_page = m_ps; end
      else if (m_op == 'h22) m_pe = clip(int'(b), PAGES);
      m_left--;
    end else begin
      m_op   = int'(b);
      m_left = nparams(b);
      if (m_left == 0) begin
        if (b <= 8'h0F) begin
          if (m_mode == 2) m_col = clip((m_col & 'hF0) | int'(b[3:0]), COLUMNS);
        end else if (b <= 8'h1F) begin
          if (m_mode == 2) m_col = clip((m_col & 'h0F) | (int'(b[3:0]) << 4), COLUMNS);
        end else if (b >= 8'hB0 && b <= 8'hB7) m_page = int'(b[2:0]) % PAGES;
        else if (b == 8'hAE) m_disp = 0;
        else if (b == 8'hAF) m_disp = 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic spi_bits(input bit dc, input logic [7:0] b, input int nbits);
    bus.oled_dc = dc;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.oled_mosi = b[i];
      clk_wait(4);
      bus.oled_clk = 1'b1;
      clk_wait(4);
      bus.oled_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    model_byte(dc, b);
    bus.oled_csn = 1'b0;
    clk_wait(4);
    spi_bits(dc, b, 8);
    clk_wait(2);
    bus.oled_csn = 1'b1;
    clk_wait(6);
    check("display_on", bus.display_on, m_disp);
    check("frame_err", bus.frame_err, m_ferr);
  endtask

  // Monitor: pops expectations on each byte strobe and checks the following write.
  bit   wr_pend = 0;
  exp_t wr_e;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (wr_pend || bus.fb_we) check("fb_we", bus.fb_we, wr_pend);
      if (wr_pend) begin
        check("fb_addr", bus.fb_addr, wr_e.addr);
        check("fb_data", bus.fb_data, wr_e.b);
        wr_pend = 0;
      end
      if (bus.byte_stb) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte_stb", bus.byte_stb, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte_out", bus.byte_out, e.b);
          check("byte_is_data", bus.byte_is_data, e.dc);
          if (e.dc) begin
            wr_pend = 1;
            wr_e    = e;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.oled_csn = 1'b1; bus.oled_dc = 1'b0; bus.oled_clk = 1'b0;
    bus.oled_mosi = 1'b0; bus.oled_rstn = 1'b1;
    model_reset();
    rst_i = 1'b1;
    clk_wait(3);
    rst_i = 1'b0;
    clk_wait(6);
    check("rst_fb_we", bus.fb_we, 0);
    check("rst_fb_addr", bus.fb_addr, 0);
    check("rst_display_on", bus.display_on, 0);
    check("rst_byte_stb", bus.byte_stb, 0);
    check("rst_byte_out", bus.byte_out, 0);
    check("rst_frame_err", bus.frame_err, 0);

    // First data byte lands at address 0
    send_byte(1'b1, 8'hA5);

    // Horizontal window 126..127 x 0..7
    send_byte(1'b0, 8'h20); send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h7E); send_byte(1'b0, 8'h7F);
    send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h07);
    for (int i = 0; i < 4; i++) send_byte(1'b1, 8'(8'h10 + i));

    // Page mode nibble addressing and end-of-row wrap
    send_byte(1'b0, 8'h20); send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h7F);
    send_byte(1'b0, 8'hB3); send_byte(1'b0, 8'h05); send_byte(1'b0, 8'h12);
    send_byte(1'b1, 8'h3A); send_byte(1'b1, 8'h3B);
    send_byte(1'b0, 8'h0F); send_byte(1'b0, 8'h17);
    send_byte(1'b1, 8'h5A); send_byte(1'b1, 8'h5B);

    // Contrast parameter swallows the first 0xAF
    send_byte(1'b0, 8'h81); send_byte(1'b0, 8'hAF);
    check("disp_after_skip", bus.display_on, 0);
    send_byte(1'b0, 8'hAF);

    // Deselect after 5 bits, then a clean byte
    bus.oled_csn = 1'b0;
    clk_wait(4);
    spi_bits(1'b0, 8'hFF, 5);
    clk_wait(2);
    bus.oled_csn = 1'b1;
    clk_wait(6);
    m_ferr = 1;
    check("frame_err_set", bus.frame_err, 1);
    send_byte(1'b0, 8'h3C);

    // Soft reset while horizontal at (40, 2)
    send_byte(1'b0, 8'h20); send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'd40); send_byte(1'b0, 8'd127);
    send_byte(1'b0, 8'h22); send_byte(1'b0, 8'd2); send_byte(1'b0, 8'd7);
    bus.oled_rstn = 1'b0;
    clk_wait(10);
    bus.oled_rstn = 1'b1;
    clk_wait(8);
    model_reset();
    check("softrst_display_on", bus.display_on, 0);
    check("softrst_frame_err", bus.frame_err, 0);
    send_byte(1'b0, 8'h05);
    send_byte(1'b1, 8'hC3);

    // Async reset in the middle of a byte emits nothing
    send_byte(1'b0, 8'hAF);
    bus.oled_csn = 1'b0;
    clk_wait(4);
    spi_bits(1'b1, 8'hE7, 4);
    rst_i = 1'b1;
    clk_wait(2);
    check("async_rst_display_on", bus.display_on, 0);
    rst_i = 1'b0;
    bus.oled_csn = 1'b1;
    clk_wait(8);
    model_reset();
    send_byte(1'b1, 8'h99);

    // Random traffic
    for (int n = 0; n < 180; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) send_byte(1'b1, 8'($urandom_range(0, 255)));
      else if (r == 4) begin
        send_byte(1'b0, 8'h20); send_byte(1'b0, 8'($urandom_range(0, 3)));
      end else if (r == 5) begin
        send_byte(1'b0, 8'h21);
        send_byte(1'b0, 8'($urandom_range(0, 140)));
        send_byte(1'b0, 8'($urandom_range(0, 140)));
      end else if (r == 6) begin
        send_byte(1'b0, 8'h22);
        send_byte(1'b0, 8'($urandom_range(0, 10)));
        send_byte(1'b0, 8'($urandom_range(0, 10)));
      end else if (r == 7) send_byte(1'b0, 8'($urandom_range(0, 31)));
      else if (r == 8) send_byte(1'b0, 8'(8'hB0 + $urandom_range(0, 7)));
      else begin
        logic [7:0] misc [8];
        misc[0] = 8'hAE; misc[1] = 8'hAF; misc[2] = 8'h81; misc[3] = 8'hA3;
        misc[4] = 8'h29; misc[5] = 8'h26; misc[6] = 8'hE3; misc[7] = 8'h8D;
        send_byte(1'b0, misc[$urandom_range(0, 7)]);
      end
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      clk_wait(1);
      waited++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
